// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one pipelined FP16 multiplier among NUM_REQ
// requesters. An id tag follows each operation down the pipe so the result can be steered back.

module fp_mul_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           issue,
  input  logic [IDW-1:0] grant_id,
  input  logic [15:0]    a,
  input  logic [15:0]    b,
  input  logic           tag_vld,
  input  logic [IDW-1:0] tag_id,
  output logic           ready,
  output logic [15:0]    a_gated,
  output logic [15:0]    b_gated,
  output logic           rsp_hit
);
  assign ready   = issue && (grant_id == IDW'(LANE));
  // Operands of lanes that lost arbitration are forced to zero so the top can OR-reduce them.
  assign a_gated = ready ? a : 16'h0000;
  assign b_gated = ready ? b : 16'h0000;
  assign rsp_hit = tag_vld && (tag_id == IDW'(LANE));
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            mul_a,
  output logic [15:0]            mul_b,
  input  logic [15:0]            mul_result,
  input  logic                   mul_overflow,
  input  logic                   mul_underflow,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_underflow,
  output logic                   busy
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0][15:0]  a_vec, b_vec, a_gated, b_gated;
  logic [NUM_REQ-1:0]        rsp_hit;
  logic [IDW-1:0]            last_grant;
  logic [IDW-1:0]            grant_id;
  logic                      found;
  logic                      issue;
  logic                      transfer;
  int                        idx;

  // Tag pipe: stage 0 is the combinational insert, stage LATENCY is the tag
  // whose result is on mul_result this cycle.
  logic [LATENCY:1]          vld_q;
  logic [LATENCY:1][IDW-1:0] id_q;
  logic [LATENCY:0]          vld_pipe;
  logic [LATENCY:0][IDW-1:0] id_pipe;

  assign a_vec = req_a;
  assign b_vec = req_b;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  assign issue    = rst && !hold && found;
  assign transfer = issue;
  assign vld_pipe = {vld_q, transfer};
  assign id_pipe  = {id_q, grant_id};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fp_mul_arb_lane #(.IDW(IDW), .LANE(i)) u_lane (
      .issue    (issue),
      .grant_id (grant_id),
      .a        (a_vec[i]),
      .b        (b_vec[i]),
      .tag_vld  (vld_pipe[LATENCY]),
      .tag_id   (id_pipe[LATENCY]),
      .ready    (req_ready[i]),
      .a_gated  (a_gated[i]),
      .b_gated  (b_gated[i]),
      .rsp_hit  (rsp_hit[i])
    );
  end

  always_comb begin
    mul_a = 16'h0000;
    mul_b = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      mul_a = mul_a | a_gated[i];
      mul_b = mul_b | b_gated[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q         <= '0;
      id_q          <= '0;
      last_grant    <= IDW'(NUM_REQ - 1);
      rsp_valid     <= '0;
      rsp_result    <= 16'h0000;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
    end else begin
      vld_q     <= vld_pipe[LATENCY-1:0];
      id_q      <= id_pipe[LATENCY-1:0];
      rsp_valid <= rsp_hit;
      if (transfer)
        last_grant <= grant_id;
      // Idle slots leave the last response visible.
      if (vld_pipe[LATENCY]) begin
        rsp_result    <= mul_result;
        rsp_overflow  <= mul_overflow;
        rsp_underflow <= mul_underflow;
      end
    end
  end

  assign busy = (|vld_q) || (|rsp_valid);

endmodule
